// File: rtl/sysid_ctrl_pkg.sv
// sysid_ctrl_pkg: shared types and constants for the system-ID check controller
package sysid_ctrl_pkg;
  localparam int DATA_W = 32;
  localparam logic SYSID_ADDR_ID = 1'b0;
  localparam logic SYSID_ADDR_TS = 1'b1;
  typedef enum logic [2:0] {IDLE, RD_ID, RD_TS, CHECK, DONE} state_t;
endpackage

// File: rtl/avm_single_read.sv
// avm_single_read: holds one Avalon-MM read until accepted or timed out
module avm_single_read import sysid_ctrl_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              go,
  input  logic              go_addr,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_ok,
  output logic              rd_tmo
);
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [TW-1:0] tmo_cnt;
  assign rd_ok = avm_read && !avm_waitrequest;
  assign rd_tmo = avm_read && avm_waitrequest && tmo_cnt == TMO_LAST;
  assign rd_data = avm_readdata;
  // stall keeps address/read frozen; otherwise the next request (or idle) is loaded
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      avm_read <= 1'b0;
      avm_address <= 1'b0;
      tmo_cnt <= '0;
    end else if (avm_read && avm_waitrequest && !rd_tmo) begin
      tmo_cnt <= tmo_cnt + 1'b1;
    end else begin
      avm_read <= go;
      avm_address <= go ? go_addr : avm_address;
      tmo_cnt <= '0;
    end
endmodule

// File: rtl/sysid_check_ctrl.sv
// sysid_check_ctrl: reads and verifies system ID and build timestamp over Avalon-MM
module sysid_check_ctrl import sysid_ctrl_pkg::*; #(
  parameter logic [DATA_W-1:0] EXPECTED_ID = 32'h0000_0000,
  parameter logic [DATA_W-1:0] EXPECTED_TS = 32'h6604_2AB7,
  parameter bit AUTO_START = 1'b1,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int MAX_RETRIES = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              start,
  output logic              avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout_err,
  output logic [DATA_W-1:0] id_value,
  output logic [DATA_W-1:0] ts_value
);
  localparam logic [3:0] RETRY_MAX = 4'(MAX_RETRIES);
  state_t state;
  logic auto_q, req_q, idle, launch, match, retry, go, go_addr, rd_ok, rd_tmo;
  logic [3:0] retry_cnt;
  logic [DATA_W-1:0] rd_data;
  assign idle = state == IDLE || state == DONE;
  avm_single_read #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_rd (
    .clock(clock),
    .reset_n(reset_n),
    .go(go),
    .go_addr(go_addr),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .rd_data(rd_data),
    .rd_ok(rd_ok),
    .rd_tmo(rd_tmo)
  );
  // read requests issued to the reader on the edge the FSM enters a read state
  always_comb begin
    launch = req_q && idle;
    match = id_value == EXPECTED_ID && ts_value == EXPECTED_TS;
    retry = state == CHECK && !match && retry_cnt < RETRY_MAX;
    go = launch || retry || (state == RD_ID && rd_ok);
    go_addr = state == RD_ID ? SYSID_ADDR_TS : SYSID_ADDR_ID;
  end
  // sequencer: start capture, word reads, compare/retry and status outputs
  always_ff @(posedge clock or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      auto_q <= AUTO_START;
      req_q <= 1'b0;
      retry_cnt <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pass <= 1'b0;
      timeout_err <= 1'b0;
      id_value <= '0;
      ts_value <= '0;
    end else begin
      auto_q <= 1'b0;
      req_q <= (start || auto_q) && idle;
      case (state)
        RD_ID:
          if (rd_ok) begin
            id_value <= rd_data;
            state <= RD_TS;
          end else if (rd_tmo) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timeout_err <= 1'b1;
          end
        RD_TS:
          if (rd_ok) begin
            ts_value <= rd_data;
            state <= CHECK;
          end else if (rd_tmo) begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            timeout_err <= 1'b1;
          end
        CHECK:
          if (retry) begin
            retry_cnt <= retry_cnt + 1'b1;
            state <= RD_ID;
          end else begin
            state <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
            pass <= match;
          end
        default:
          if (launch) begin
            state <= RD_ID;
            busy <= 1'b1;
            done <= 1'b0;
            pass <= 1'b0;
            timeout_err <= 1'b0;
            retry_cnt <= '0;
          end
      endcase
    end
endmodule

// File: tb/tb_sysid_check_ctrl.sv
// tb_sysid_check_ctrl: directed checks of the system-ID check controller
module tb_sysid_check_ctrl;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic avm_address, avm_read, avm_waitrequest;
  logic [31:0] avm_readdata;
  logic busy, done, pass, timeout_err;
  logic [31:0] id_value, ts_value;
  logic [31:0] id_rsp = 32'h0;
  logic [31:0] ts_rsp = 32'h6604_2AB7;
  logic stuck = 1'b0;
  int stall_len = 0;
  int stalled = 0;
  int reads = 0;
  int ts_reads = 0;
  int unstable = 0;
  logic hold_q = 1'b0;
  logic addr_q = 1'b0;
  int checks = 0;
  int failures = 0;
  int r0, t0;

  sysid_check_ctrl #(.TIMEOUT_CYCLES(8)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .avm_address(avm_address),
    .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata(avm_readdata),
    .busy(busy),
    .done(done),
    .pass(pass),
    .timeout_err(timeout_err),
    .id_value(id_value),
    .ts_value(ts_value)
  );

  always #5 clock = ~clock;

  assign avm_waitrequest = stuck || (avm_read && !avm_address && stalled < stall_len);
  assign avm_readdata = avm_address ? ts_rsp : id_rsp;

  // slave model bookkeeping and Avalon hold-stability monitor
  always @(posedge clock) begin
    stalled <= (avm_read && avm_waitrequest) ? stalled + 1 : 0;
    if (avm_read && !avm_waitrequest) reads <= reads + 1;
    if (avm_read && avm_address) ts_reads <= ts_reads + 1;
    if (reset_n && hold_q && (avm_address != addr_q || (!avm_read && !timeout_err)))
      unstable <= unstable + 1;
    hold_q <= avm_read && avm_waitrequest && reset_n;
    addr_q <= avm_address;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clock);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int lim);
    int n = 0;
    @(posedge clock);
    #1;
    while (!done && n < lim) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset values
    repeat (3) @(posedge clock);
    #1;
    check("rst_read", avm_read, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    check("rst_tmo", timeout_err, 0);
    check("rst_ts", ts_value, 0);
    // test 1: auto start, no stalls
    @(negedge clock) reset_n = 1'b1;
    step();
    check("t1_e0_read", avm_read, 0);
    step();
    check("t1_e1_read", avm_read, 1);
    check("t1_e1_addr", avm_address, 0);
    check("t1_e1_busy", busy, 1);
    step();
    check("t1_e2_read", avm_read, 1);
    check("t1_e2_addr", avm_address, 1);
    step();
    check("t1_e3_read", avm_read, 0);
    check("t1_e3_done", done, 0);
    check("t1_e3_busy", busy, 1);
    step();
    check("t1_e4_done", done, 1);
    check("t1_e4_pass", pass, 1);
    check("t1_e4_busy", busy, 0);
    check("t1_ts", ts_value, 32'h6604_2AB7);
    check("t1_id", id_value, 32'h0);
    // test 2: five stalls on word 0
    stall_len = 5;
    pulse_start();
    step();
    check("t2_c1_read", avm_read, 1);
    check("t2_c1_addr", avm_address, 0);
    repeat (5) step();
    check("t2_c6_read", avm_read, 1);
    check("t2_c6_addr", avm_address, 0);
    step();
    check("t2_c7_addr", avm_address, 1);
    wait_done("t2_done", 10);
    check("t2_pass", pass, 1);
    check("t2_stable", unstable, 0);
    stall_len = 0;
    // test 3: timestamp mismatch, two retries
    ts_rsp = 32'h6604_2AB8;
    r0 = reads;
    pulse_start();
    wait_done("t3_done", 40);
    check("t3_reads", reads - r0, 6);
    check("t3_pass", pass, 0);
    check("t3_ts", ts_value, 32'h6604_2AB8);
    check("t3_tmo", timeout_err, 0);
    ts_rsp = 32'h6604_2AB7;
    // test 4: waitrequest stuck, timeout after 8 stalled cycles
    stuck = 1'b1;
    t0 = ts_reads;
    pulse_start();
    repeat (8) step();
    check("t4_c8_read", avm_read, 1);
    check("t4_c8_done", done, 0);
    step();
    check("t4_c9_read", avm_read, 0);
    check("t4_done", done, 1);
    check("t4_tmo", timeout_err, 1);
    check("t4_pass", pass, 0);
    check("t4_no_ts", ts_reads - t0, 0);
    stuck = 1'b0;
    // test 5: start during RD_TS ignored, then async reset mid RD_ID
    pulse_start();
    step();
    step();
    check("t5_in_ts", avm_address, 1);
    start = 1'b1;
    step();
    start = 1'b0;
    check("t5_check_done", done, 0);
    step();
    check("t5_done", done, 1);
    check("t5_tmo_clr", timeout_err, 0);
    repeat (3) step();
    check("t5_ign_done", done, 1);
    check("t5_ign_busy", busy, 0);
    check("t5_ign_read", avm_read, 0);
    stall_len = 3;
    pulse_start();
    step();
    check("t5_rd_id", avm_read, 1);
    #2 reset_n = 1'b0;
    #1;
    check("t5_rst_read", avm_read, 0);
    check("t5_rst_busy", busy, 0);
    check("t5_rst_done", done, 0);
    check("t5_rst_pass", pass, 0);
    check("t5_rst_ts", ts_value, 0);
    stall_len = 0;
    @(negedge clock) reset_n = 1'b1;
    repeat (5) step();
    check("t5_auto_done", done, 1);
    check("t5_auto_pass", pass, 1);
    check("t5_stable", unstable, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
